// File: rtl/sram_rd_arbiter_pkg.sv
// Shared constants for the two-master SRAM-like to AXI read arbiter.
package sram_rd_arbiter_pkg;

  // Default ARIDs for the instruction and data masters
  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  // Index of each master in the per-port vectors
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  // Fixed AR fields: single-beat INCR, normal access, no cache hints
  localparam logic [7:0] AR_LEN   = 8'd0;
  localparam logic [1:0] AR_BURST = 2'b01;
  localparam logic [1:0] AR_LOCK  = 2'b00;
  localparam logic [3:0] AR_CACHE = 4'b0000;
  localparam logic [2:0] AR_PROT  = 3'b000;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

endpackage

// File: rtl/sram_rd_arbiter_if.sv
// Bus bundle: two SRAM-like read masters on one side, AXI AR/R on the other.
interface sram_rd_arbiter_if;
  logic        i_req;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        d_req;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Arbiter view
  modport slave (
    input  i_req, i_size, i_addr, d_req, d_size, d_addr,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // Environment view (core masters plus AXI slave)
  modport master (
    output i_req, i_size, i_addr, d_req, d_size, d_addr,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sram_rd_arbiter_port.sv
// Per-master read-return tracker: busy flag, data capture and data_ok pulse.
module sram_rd_port #(
  parameter logic [3:0] ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grant,
  input  logic        rvalid,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        data_ok,
  output logic [31:0] cap_data
);

  logic        busy_reg;
  logic        data_ok_reg;
  logic [31:0] cap_reg;
  logic        hit;

  // A beat belongs to us only while a read is outstanding and not yet returned
  assign hit = rvalid && (rid == ID) && busy_reg && !data_ok_reg;

  // Track the outstanding read and capture its single return beat
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg    <= 1'b0;
      data_ok_reg <= 1'b0;
      cap_reg     <= '0;
    end else begin
      data_ok_reg <= hit;
      if (hit) begin
        cap_reg <= rdata;
      end
      // busy drops on the same edge that ends the data_ok pulse
      if (grant) begin
        busy_reg <= 1'b1;
      end else if (data_ok_reg) begin
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy     = busy_reg;
  assign data_ok  = data_ok_reg;
  assign cap_data = cap_reg;

endmodule

// File: rtl/sram_rd_arbiter.sv
// Two-master read arbiter onto one AXI read path; data port has priority,
// an age counter keeps instruction fetch from starving.
module sram_rd_arbiter
  import sram_rd_arbiter_pkg::*;
#(
  parameter logic [2:0] STARVE_LIMIT = 3'd4,
  parameter logic [3:0] INST_ID      = INST_ID_DEF,
  parameter logic [3:0] DATA_ID      = DATA_ID_DEF
) (
  input logic              clk,
  input logic              reset,
  sram_rd_arbiter_if.slave bus
);

  ar_state_t         state_reg;
  logic              arvalid_reg;
  logic [31:0]       araddr_reg;
  logic [1:0]        arsize_reg;
  logic [3:0]        arid_reg;
  logic [2:0]        starve_reg;

  logic [1:0]        req;
  logic [1:0]        busy;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [1:0]        data_ok;
  logic [1:0][31:0]  cap_data;
  logic              starved;
  logic              unused_ok;

  assign req      = {bus.d_req, bus.i_req};
  assign eligible = req & ~busy;
  assign starved  = (starve_reg == STARVE_LIMIT);

  // Grant decision for the current AR_IDLE cycle
  always_comb begin
    grant = '0;
    if (!reset && state_reg == AR_IDLE) begin
      if (eligible[PORT_I] && (!eligible[PORT_D] || starved)) begin
        grant[PORT_I] = 1'b1;
      end else if (eligible[PORT_D]) begin
        grant[PORT_D] = 1'b1;
      end
    end
  end

  // AR channel FSM: latch the winner, hold arvalid until the slave takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= AR_IDLE;
      arvalid_reg <= 1'b0;
      araddr_reg  <= '0;
      arsize_reg  <= '0;
      arid_reg    <= '0;
    end else begin
      case (state_reg)
        AR_IDLE: begin
          if (|grant) begin
            state_reg   <= AR_SEND;
            arvalid_reg <= 1'b1;
            araddr_reg  <= grant[PORT_I] ? bus.i_addr : bus.d_addr;
            arsize_reg  <= grant[PORT_I] ? bus.i_size : bus.d_size;
            arid_reg    <= grant[PORT_I] ? INST_ID    : DATA_ID;
          end
        end
        AR_SEND: begin
          if (bus.arready) begin
            state_reg   <= AR_IDLE;
            arvalid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= AR_IDLE;
          arvalid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Age counter: counts idle cycles where i was ready but d took the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (grant[PORT_I]) begin
      starve_reg <= '0;
    end else if (eligible[PORT_I] && grant[PORT_D] && !starved) begin
      starve_reg <= starve_reg + 3'd1;
    end
  end

  // One return tracker per master, keyed by that master's ARID
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      sram_rd_port #(
        .ID ((gi == PORT_I) ? INST_ID : DATA_ID)
      ) u_port (
        .clk      (clk),
        .reset    (reset),
        .grant    (grant[gi]),
        .rvalid   (bus.rvalid),
        .rid      (bus.rid),
        .rdata    (bus.rdata),
        .busy     (busy[gi]),
        .data_ok  (data_ok[gi]),
        .cap_data (cap_data[gi])
      );
    end
  endgenerate

  assign bus.i_addr_ok = grant[PORT_I];
  assign bus.d_addr_ok = grant[PORT_D];
  assign bus.i_data_ok = data_ok[PORT_I];
  assign bus.d_data_ok = data_ok[PORT_D];
  assign bus.i_rdata   = cap_data[PORT_I];
  assign bus.d_rdata   = cap_data[PORT_D];

  assign bus.arid    = arid_reg;
  assign bus.araddr  = araddr_reg;
  assign bus.arlen   = AR_LEN;
  assign bus.arsize  = {1'b0, arsize_reg};
  assign bus.arburst = AR_BURST;
  assign bus.arlock  = AR_LOCK;
  assign bus.arcache = AR_CACHE;
  assign bus.arprot  = AR_PROT;
  assign bus.arvalid = arvalid_reg;

  // Every beat is single and every response is taken, so these carry nothing
  assign bus.rready = 1'b1;
  assign unused_ok  = &{1'b0, bus.rresp, bus.rlast};

endmodule
